// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH run cycles plus a one-cycle done pulse.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output Ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             z;
    logic             c;

    // The lab2 full-adder cell, fed with the current LSB pair and the stored carry.
    always_comb begin
        z = a_sh[0] ^ b_sh[0] ^ carry;
        c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        res_next = res >> 1;
        res_next[WIDTH-1] = z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        res   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_next;
                    carry <= c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Sum/Cout only ever see the completed result.
                        Sum   <= res_next;
                        Cout  <= c;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry currently holds the carry into the MSB.
                        Ovf   <= carry ^ c;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for timing/control cases, a 4-bit one for the sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .Ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
        , .Ovf(ovf4)
`endif
    );

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx; cin8 = 1'bx;
    endtask

    // Returns at the negedge of the done cycle, or flags a timeout.
    task automatic wait_done8(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: done never observed, wanted a pulse within 40 cycles", name);
        end
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        start_op8(a, b, c);
        wait_done8(name);
        total++;
        if (sum8 !== exp_sum || cout8 !== exp_cout) begin
            bad++;
            $display("FAIL %s: got Sum=%h Cout=%b, want Sum=%h Cout=%b", name, sum8, cout8, exp_sum, exp_cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start8 = 0; start4 = 0;
        a8 = 0; b8 = 0; cin8 = 0; a4 = 0; b4 = 0; cin4 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy8 !== 0 || done8 !== 0 || sum8 !== 8'h00 || cout8 !== 0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b Sum=%h Cout=%b, want all zero", busy8, done8, sum8, cout8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timing;
        start_op8(8'h3C, 8'h15, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            total++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                bad++;
                $display("FAIL timing_run cycle %0d: busy=%b done=%b, want busy=1 done=0", i, busy8, done8);
            end
        end
        @(negedge clk);
        total++;
        if (busy8 !== 0 || done8 !== 1 || sum8 !== 8'h51 || cout8 !== 0) begin
            bad++;
            $display("FAIL timing_done cycle 9: busy=%b done=%b Sum=%h Cout=%b, want 0 1 51 0", busy8, done8, sum8, cout8);
        end
        @(negedge clk);
        total++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL timing_pulse cycle 10: done=%b busy=%b, want 0 0", done8, busy8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry;
        run8("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("ff_plus_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run8("zero_plus_zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run8("a5_plus_5a_c1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic test_ignore_start;
        start_op8(8'h10, 8'h20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8("ignore_start");
        total++;
        if (sum8 !== 8'h30 || cout8 !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_sum: got Sum=%h Cout=%b, want 30 0", sum8, cout8);
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            total++;
            if (sum8 !== 8'h30 || busy8 !== 1'b0 || done8 !== 1'b0) begin
                bad++;
                $display("FAIL hold_idle %0d: Sum=%h busy=%b done=%b, want 30 0 0", i, sum8, busy8, done8);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        start_op8(8'h80, 8'h80, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy8 !== 0 || done8 !== 0 || sum8 !== 8'h00 || cout8 !== 0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b Sum=%h Cout=%b, want all zero", busy8, done8, sum8, cout8);
        end
        @(posedge clk); #1;
        run8("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a, b;
            logic       c;
            logic [4:0] exp;
            bit         seen;
            a = i[3:0]; b = i[7:4]; c = i[8];
            exp = 5'(a) + 5'(b) + 5'(c);
            a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (done4 === 1'b1) seen = 1;
            end
            total++;
            if (!seen || {cout4, sum4} !== exp) begin
                bad++;
                $display("FAIL sweep4 a=%h b=%h c=%b: got done=%b {Cout,Sum}=%h, want %h", a, b, c, done4, {cout4, sum4}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        run8("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        total++;
        if (ovf8 !== 1'b1) begin bad++; $display("FAIL ovf_7f_01: Ovf=%b want 1", ovf8); end
        run8("ovf_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1);
        total++;
        if (ovf8 !== 1'b1) begin bad++; $display("FAIL ovf_80_ff: Ovf=%b want 1", ovf8); end
        run8("ovf_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        total++;
        if (ovf8 !== 1'b0) begin bad++; $display("FAIL ovf_05_03: Ovf=%b want 0", ovf8); end
    endtask
`endif

    initial begin
        test_reset;
        test_timing;
        test_carry;
        test_ignore_start;
        test_mid_reset;
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf;
`endif
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, built around the lab2 1-bit full adder cell: X, Y and Cin in; Z (sum) and Cout out.
- Holds two operands in shift registers and presents one bit pair per clock to the full-adder function, LSB first.
- Registers the carry between cycles and shifts sum bits into a result register.
- Sits upstream of and feeds the bit_adder stage; it is the sequential wrapper the lab2 ALU uses for multi-bit addition with one adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk    input   1      single clock, all state updates on rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      request; sampled only when not busy
- A      input   WIDTH  operand A, captured on accepted start
- B      input   WIDTH  operand B, captured on accepted start
- Cin    input   1      initial carry, captured on accepted start
- busy   output  1      high while bits are being processed
- done   output  1      one-cycle pulse: Sum/Cout valid
- Sum    output  WIDTH  result A+B+Cin mod 2^WIDTH
- Cout   output  1      final carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. rst high at a rising edge forces state IDLE, busy=0, done=0, Sum=0, Cout=0, and clears the internal shift registers, carry and bit counter. rst has priority over every other input, including mid-operation; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture A, B and Cin into a_sh, b_sh and carry; clear the counter; go to RUN; busy=1 from the next cycle.
  - Sum and Cout keep their last values.
- RUN, each edge:
  - z = a_sh[0]^b_sh[0]^carry.
  - c = majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by 1.
  - Shift z into the result MSB, shifting the result right.
  - carry <= c; counter++.
  - After the WIDTH-th bit edge: go to DONE, Sum <= completed result, Cout <= c.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally. start during DONE is ignored.
- Latency: an accepted start at edge k gives busy=1 during cycles k+1..k+WIDTH, and done=1 during cycle k+WIDTH+1. Throughput is one addition per WIDTH+2 cycles.
- Sum/Cout update:
  - They change only on entry to DONE and on reset.
  - They hold stable until the next completed operation; intermediate partial results never appear on Sum.
- start handling: start while busy or done is high is ignored, not queued. A, B and Cin are don't-care except at the accepting edge.
- WIDTH=1: one RUN cycle; done at k+2.
- Arithmetic: unsigned. {Cout,Sum} equals A+B+Cin exactly for all inputs; wrap-around mod 2^WIDTH, with the overflow bit in Cout.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit), signed two's-complement overflow.
  - Ovf = carry into MSB XOR carry out of MSB, latched on entry to DONE alongside Sum/Cout.
  - Reset value 0; holds like Sum.
- Undefined: no Ovf port and no related logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, A=0x3C, B=0x15, Cin=0, start at edge 0 -> busy high cycles 1..8; done pulses cycle 9 only; Sum=0x51, Cout=0.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1 (full carry ripple).
- Accepted start with A=0x10, B=0x20; pulse start with A=0xAA, B=0x55 during cycle 4 -> second start ignored; Sum=0x30; Sum held at 0x30 through 5 idle cycles after done.
- Start A=0x80, B=0x80; assert rst at cycle 4 -> next cycle busy=0, done=0, Sum=0, Cout=0. A new start then completes normally, e.g. 0x01+0x02 -> 0x03.
- Exhaustive WIDTH=4 sweep, all A, B, Cin (512 cases), back-to-back starts on cycle after done -> {Cout,Sum} == A+B+Cin for every case.
- SERIAL_ADDER_OVF_EN defined, WIDTH=8:
  - 0x7F+0x01 -> Sum=0x80, Ovf=1, Cout=0.
  - 0x80+0xFF -> Sum=0x7F, Ovf=1, Cout=1.
  - 0x05+0x03 -> Ovf=0.
